// File: rtl/oam_dma_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter_pkg
//
// Purpose : Shared CPU-side constants and types for the OAM DMA arbiter.
//           Holds the DMA register address, the HRAM window, the OAM length,
//           the DMA state enumeration and the source-page remap helper.
//
// Contents:
//   DMA_REG_ADR  - address of the DMA source-page register (FF46)
//   HRAM_LO/HI   - HRAM window, always reachable by the CPU, never on ext bus
//   OAM_LEN      - number of bytes moved by one transfer
//   dma_state_t  - DMA_IDLE / DMA_START / DMA_XFER
//   dma_src_hi() - maps the register value to the source page (echo remap)
// -----------------------------------------------------------------------------
package oam_dma_arbiter_pkg;

   localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
   localparam logic [15:0] HRAM_LO     = 16'hFF80;
   localparam logic [15:0] HRAM_HI     = 16'hFFFE;
   localparam int          OAM_LEN     = 160;

   // Index of the final byte of a transfer.
   localparam logic [7:0]  OAM_LAST    = 8'(OAM_LEN - 1);

   // Pages E0-FF are the echo of C0-DF; the DMA source is pulled down by 0x20.
   localparam logic [7:0]  ECHO_BASE   = 8'hE0;
   localparam logic [7:0]  ECHO_OFS    = 8'h20;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   function automatic logic [7:0] dma_src_hi(input logic [7:0] reg_val);
      logic [7:0] hi;
      if (reg_val >= ECHO_BASE) begin
         hi = reg_val - ECHO_OFS;
      end else begin
         hi = reg_val;
      end
      return hi;
   endfunction

endpackage : oam_dma_arbiter_pkg

// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
//
// Purpose : OAM DMA engine plus main-bus arbiter. A CPU write to FF46 latches
//           the source page and, after one START M-cycle, copies 160 bytes
//           from {src_hi, idx} on the main bus into OAM, one byte per M-cycle.
//           While the copy runs the CPU is locked out of the main bus except
//           for HRAM (FF80-FFFE) and the FF46 register itself.
//
// Ports   :
//   clk          in   system clock, all state changes on rising edge
//   nreset       in   synchronous active-low reset
//   ce_m         in   one-clk strobe at the end (T4) of every M-cycle
//   cpu_adr/dout in   CPU address / write data
//   cpu_rd/wr    in   CPU read / write request (both high = write)
//   cpu_din      out  read data returned to the CPU
//   ext_adr/rd/wr/dout out, ext_din in   main bus
//   oam_adr/we/dout   out                OAM write port
//   dma_active   out  high while DMA owns the main bus (state XFER)
//   dbg_state_o  out  raw FSM state, for observation only
//
// Handshake: there is no valid/ready pair; a CPU access is a level request
// that the arbiter services combinationally in the same clk, and register
// side effects (FF46 writes) take place only at the ce_m strobe.
// -----------------------------------------------------------------------------
module oam_dma_arbiter
   import oam_dma_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        nreset,
   input  logic        ce_m,

   input  logic [15:0] cpu_adr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,

   output logic [15:0] ext_adr,
   output logic        ext_rd,
   output logic        ext_wr,
   output logic [7:0]  ext_dout,
   input  logic [7:0]  ext_din,

   output logic [7:0]  oam_adr,
   output logic        oam_we,
   output logic [7:0]  oam_dout,

   output logic        dma_active,
   output logic [1:0]  dbg_state_o
);

   // Plain-vector state constants, kept bit-identical to dma_state_t.
   localparam logic [1:0] ST_IDLE  = DMA_IDLE;
   localparam logic [1:0] ST_START = DMA_START;
   localparam logic [1:0] ST_XFER  = DMA_XFER;

   logic [1:0] state_q,   state_d;
   logic [7:0] idx_q,     idx_d;
   logic [7:0] dma_reg_q, dma_reg_d;

   logic       is_ff46;
   logic       is_hram;
   logic       acc_wr;
   logic       acc_rd;
   logic       ff46_wr;
   logic       xfer;
   logic [7:0] src_hi;

   // ---------------------------------------------------------------------------
   // Access decode. A simultaneous rd+wr is a write, so reads are masked by wr.
   // ---------------------------------------------------------------------------
   assign is_ff46 = (cpu_adr == DMA_REG_ADR);
   assign is_hram = (cpu_adr >= HRAM_LO) && (cpu_adr <= HRAM_HI);
   assign acc_wr  = cpu_wr;
   assign acc_rd  = cpu_rd & ~cpu_wr;
   assign ff46_wr = ce_m & acc_wr & is_ff46;

   assign xfer    = (state_q == ST_XFER);
   assign src_hi  = dma_src_hi(dma_reg_q);

   // ---------------------------------------------------------------------------
   // Next-state logic. The FF46 write is applied after the normal advance so
   // that it overrides it (restart from any state), while the output mux below
   // still performs the current XFER byte in the same M-cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      dma_reg_d = dma_reg_q;

      if (ce_m) begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_START: begin
               state_d = ST_XFER;
            end
            ST_XFER: begin
               if (idx_q == OAM_LAST) begin
                  state_d = ST_IDLE;
                  idx_d   = 8'h00;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
            default: begin
               // Unused encoding: fall back to IDLE.
               state_d = ST_IDLE;
               idx_d   = 8'h00;
            end
         endcase

         if (ff46_wr) begin
            dma_reg_d = cpu_dout;
            idx_d     = 8'h00;
            state_d   = ST_START;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         idx_q     <= 8'h00;
         dma_reg_q <= 8'hFF;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dma_reg_q <= dma_reg_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus mux.
   //   XFER : DMA drives the main bus and writes OAM at each ce_m.
   //   else : CPU mirrored onto the main bus, with FF46 kept internal and HRAM
   //          never raising ext_rd/ext_wr. The address/data are only passed
   //          through while an access is requested so an idle CPU leaves the
   //          bus at zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      ext_adr  = 16'h0000;
      ext_rd   = 1'b0;
      ext_wr   = 1'b0;
      ext_dout = 8'h00;
      oam_adr  = 8'h00;
      oam_we   = 1'b0;
      oam_dout = 8'h00;

      if (xfer) begin
         ext_adr  = {src_hi, idx_q};
         ext_rd   = 1'b1;
         oam_we   = ce_m;
         oam_adr  = idx_q;
         oam_dout = ext_din;
      end else if (!is_ff46) begin
         if (acc_rd || acc_wr) begin
            ext_adr = cpu_adr;
         end
         if (acc_wr) begin
            ext_dout = cpu_dout;
         end
         ext_rd = acc_rd & ~is_hram;
         ext_wr = acc_wr & ~is_hram;
      end
   end

   // CPU read data: FF46 always returns the register; during XFER anything
   // outside HRAM is blocked and reads as open bus.
   always_comb begin
      if (is_ff46) begin
         cpu_din = dma_reg_q;
      end else if (xfer && !is_hram) begin
         cpu_din = 8'hFF;
      end else begin
         cpu_din = ext_din;
      end
   end

   assign dma_active  = xfer;
   assign dbg_state_o = state_q;

endmodule : oam_dma_arbiter
